// File: rtl/mux_8_32.sv
// mux_8_32: byte-to-word packer.
// Gathers four valid bytes, most significant byte first, and presents them as
// one registered 32-bit word with a single-cycle valid strobe. If the byte
// stream stalls inside a word for MAX_GAP cycles, the partial word is dropped
// and err_partial pulses. Everything runs on clk_4f, and reset is
// synchronous and active-low.
module mux_8_32 #(
  parameter int unsigned MAX_GAP = 3  // legal range 1..15
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err_partial,
  output logic [1:0]  byte_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [3:0] LP_MAX_GAP = 4'(MAX_GAP);

  state_t      r_state;
  logic [31:0] r_acc;
  logic [3:0]  r_gap;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_data_out;
  logic        r_valid_out;
  logic        r_err_partial;

  logic [3:0]  w_gap_next;
  logic        w_gap_hit;

  // Outputs come straight from registers.
  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;
  assign err_partial = r_err_partial;
  assign byte_cnt    = r_byte_cnt;

  // The idle-cycle count this edge would reach, and whether that count forces a discard.
  always_comb begin
    w_gap_next = r_gap + 4'd1;
    if (w_gap_next == LP_MAX_GAP) begin
      w_gap_hit = 1'b1;
    end else begin
      w_gap_hit = 1'b0;
    end
  end

  // Packing FSM. Both strobes default low, so each can stay high for only one cycle.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_acc         <= 32'h0;
      r_gap         <= 4'd0;
      r_byte_cnt    <= 2'd0;
      r_data_out    <= 32'h0;
      r_valid_out   <= 1'b0;
      r_err_partial <= 1'b0;
    end else begin
      r_valid_out   <= 1'b0;
      r_err_partial <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_acc      <= {data_in, 24'h0};
            r_byte_cnt <= 2'd1;
            r_gap      <= 4'd0;
            r_state    <= ST_COLLECT;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (valid_in) begin
            // A valid byte always wins over a pending gap discard.
            if (r_byte_cnt == 2'd3) begin
              r_data_out  <= {r_acc[31:8], data_in};
              r_valid_out <= 1'b1;
              r_acc       <= 32'h0;
              r_byte_cnt  <= 2'd0;
              r_gap       <= 4'd0;
              r_state     <= ST_IDLE;
            end else begin
              case (r_byte_cnt)
                2'd1:    r_acc[23:16] <= data_in;
                2'd2:    r_acc[15:8]  <= data_in;
                default: r_acc        <= r_acc;
              endcase
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_gap      <= 4'd0;
            end
          end else if (w_gap_hit) begin
            // The stream stalled too long. Drop the partial word and leave data_out untouched.
            r_acc         <= 32'h0;
            r_byte_cnt    <= 2'd0;
            r_gap         <= 4'd0;
            r_err_partial <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_gap <= w_gap_next;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_acc      <= 32'h0;
          r_gap      <= 4'd0;
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_8_32.sv
// tb_mux_8_32: scoreboard bench for the byte-to-word packer.
// Each test pushes the word it expects into a queue in the same cycle that it
// drives the 4th byte. The bench pops that word when valid_out is seen one
// edge later.
module tb_mux_8_32;

  logic        clk_4f;
  logic        reset;
  logic        valid_in;
  logic [7:0]  data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        err_partial;
  logic [1:0]  byte_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_word = 32'h0;

  mux_8_32 #(.MAX_GAP(3)) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .err_partial (err_partial),
    .byte_cnt    (byte_cnt)
  );

  // Byte-rate clock.
  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle and check the outputs 1 time unit after the edge.
  // When done is set, wrd is pushed to the scoreboard as the word that must appear.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic done, input logic [31:0] wrd,
                      input logic exp_err, input logic [1:0] exp_cnt);
    reset    = 1'b1;
    valid_in = v;
    data_in  = d;
    if (done) sb_q.push_back(wrd);
    @(posedge clk_4f);
    #1;
    check_val({tag, "/valid_out"}, {31'h0, valid_out}, {31'h0, done});
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        check_val({tag, "/sb_empty"}, 32'd1, 32'd0);
      end else begin
        last_word = sb_q.pop_front();
        check_val({tag, "/data_out"}, data_out, last_word);
      end
    end else begin
      check_val({tag, "/hold"}, data_out, last_word);
    end
    if (sb_q.size() != 0) begin
      check_val({tag, "/sb_left"}, sb_q.size(), 32'd0);
      sb_q.delete();
    end
    check_val({tag, "/err_partial"}, {31'h0, err_partial}, {31'h0, exp_err});
    check_val({tag, "/byte_cnt"}, {30'h0, byte_cnt}, {30'h0, exp_cnt});
  endtask

  // Hold reset low for one cycle while driving a valid byte. All outputs must clear.
  task automatic rst_step(input string tag);
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'hAA;
    @(posedge clk_4f);
    #1;
    last_word = 32'h0;
    sb_q.delete();
    check_val({tag, "/data_out"}, data_out, 32'h0);
    check_val({tag, "/valid_out"}, {31'h0, valid_out}, 32'h0);
    check_val({tag, "/err_partial"}, {31'h0, err_partial}, 32'h0);
    check_val({tag, "/byte_cnt"}, {30'h0, byte_cnt}, 32'h0);
    reset = 1'b1;
  endtask

  // Send four bytes back-to-back, starting from the idle state.
  task automatic send_word(input string tag, input logic [31:0] w);
    step(tag, 1'b1, w[31:24], 1'b0, 32'h0, 1'b0, 2'd1);
    step(tag, 1'b1, w[23:16], 1'b0, 32'h0, 1'b0, 2'd2);
    step(tag, 1'b1, w[15:8],  1'b0, 32'h0, 1'b0, 2'd3);
    step(tag, 1'b1, w[7:0],   1'b1, w,     1'b0, 2'd0);
  endtask

  initial begin
    logic [31:0] rw;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset hold for 3 cycles with valid bytes present.
    for (int i = 0; i < 3; i++) rst_step("reset_hold");

    // Idle cycles in IDLE change nothing.
    step("idle", 1'b0, 8'h77, 1'b0, 32'h0, 1'b0, 2'd0);
    step("idle", 1'b0, 8'h77, 1'b0, 32'h0, 1'b0, 2'd0);

    // Basic pack.
    send_word("basic", 32'hFD554488);
    step("basic_after", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd0);

    // Back-to-back words: two pulses exactly 4 cycles apart.
    send_word("b2b_1", 32'hFFAABB22);
    send_word("b2b_2", 32'hCCBBAAFF);

    // Two idle cycles inside a word are tolerated.
    step("gap_ok", 1'b1, 8'h12, 1'b0, 32'h0, 1'b0, 2'd1);
    step("gap_ok", 1'b1, 8'h34, 1'b0, 32'h0, 1'b0, 2'd2);
    step("gap_ok", 1'b0, 8'hEE, 1'b0, 32'h0, 1'b0, 2'd2);
    step("gap_ok", 1'b0, 8'hEE, 1'b0, 32'h0, 1'b0, 2'd2);
    step("gap_ok", 1'b1, 8'h56, 1'b0, 32'h0, 1'b0, 2'd3);
    step("gap_ok", 1'b1, 8'h78, 1'b1, 32'h12345678, 1'b0, 2'd0);

    // Discard on the 3rd consecutive idle cycle. data_out keeps its old value.
    step("discard", 1'b1, 8'hBB, 1'b0, 32'h0, 1'b0, 2'd1);
    step("discard", 1'b1, 8'hCC, 1'b0, 32'h0, 1'b0, 2'd2);
    step("discard", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd2);
    step("discard", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd2);
    step("discard", 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 2'd0);
    send_word("after_discard", 32'hDDEE1122);

    // A valid byte arriving in the cycle that would have discarded wins, and the gap count restarts.
    step("valid_wins", 1'b1, 8'hAB, 1'b0, 32'h0, 1'b0, 2'd1);
    step("valid_wins", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd1);
    step("valid_wins", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd1);
    step("valid_wins", 1'b1, 8'hCD, 1'b0, 32'h0, 1'b0, 2'd2);
    step("valid_wins", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd2);
    step("valid_wins", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd2);
    step("valid_wins", 1'b1, 8'hEF, 1'b0, 32'h0, 1'b0, 2'd3);
    step("valid_wins", 1'b1, 8'h01, 1'b1, 32'hABCDEF01, 1'b0, 2'd0);

    // Reset mid-word drops the partial word without err_partial and clears data_out.
    step("mid_reset", 1'b1, 8'h01, 1'b0, 32'h0, 1'b0, 2'd1);
    step("mid_reset", 1'b1, 8'h02, 1'b0, 32'h0, 1'b0, 2'd2);
    rst_step("mid_reset_rst");
    send_word("mid_reset_word", 32'h03040506);

    // A few random back-to-back words.
    for (int k = 0; k < 4; k++) begin
      rw = $urandom;
      send_word("random", rw);
    end
    step("tail", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
